// File: rtl/cmp_pkg.sv
// Shared types for the word comparator accumulator: FSM states, beat classes
// and the one-hot relation encoding used on the {g,e,l} outputs.
package cmp_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BEAT_EQ  = 2'd0,
        BEAT_GT  = 2'd1,
        BEAT_LT  = 2'd2,
        BEAT_ERR = 2'd3
    } beat_e;

    localparam logic [2:0] REL_GT   = 3'b100;
    localparam logic [2:0] REL_EQ   = 3'b010;
    localparam logic [2:0] REL_LT   = 3'b001;
    localparam logic [2:0] REL_NONE = 3'b000;
endpackage

// File: rtl/cmp_result_accumulator_if.sv
// Beat input, result handshake and status signals of the accumulator.
interface cmp_result_accumulator_if;
    logic start_in;
    logic bit_valid_in;
    logic g_in;
    logic e_in;
    logic l_in;
    logic res_ready_in;
    logic bit_ready_out;
    logic g_out;
    logic e_out;
    logic l_out;
    logic done_out;
    logic err_out;

    modport slave (
        input  start_in, bit_valid_in, g_in, e_in, l_in, res_ready_in,
        output bit_ready_out, g_out, e_out, l_out, done_out, err_out
    );

    modport master (
        output start_in, bit_valid_in, g_in, e_in, l_in, res_ready_in,
        input  bit_ready_out, g_out, e_out, l_out, done_out, err_out
    );
endinterface

// File: rtl/cmp_bit_decider.sv
// Classifies one slice beat; anything that is not exactly one-hot is an error.
module cmp_bit_decider
    import cmp_pkg::*;
(
    input  logic  g_i,
    input  logic  e_i,
    input  logic  l_i,
    output beat_e cls_o
);
    always_comb begin
        case ({g_i, e_i, l_i})
            REL_GT:  cls_o = BEAT_GT;
            REL_EQ:  cls_o = BEAT_EQ;
            REL_LT:  cls_o = BEAT_LT;
            default: cls_o = BEAT_ERR;
        endcase
    end
endmodule

// File: rtl/cmp_result_accumulator.sv
// Folds MSB-first per-bit relation beats into a word relation; the first
// deciding beat wins and the result is held until the consumer takes it.
module cmp_result_accumulator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    cmp_result_accumulator_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            decided_q, decided_d;
    logic [2:0]      rel_q, rel_d;
    logic            err_q, err_d;
    logic            rdy_q, rdy_d;
    logic            done_q, done_d;
    logic [2:0]      res_q, res_d;
    beat_e           cls;
    logic            restart;
    logic            accept;

    cmp_bit_decider u_decider (
        .g_i   (bus.g_in),
        .e_i   (bus.e_in),
        .l_i   (bus.l_in),
        .cls_o (cls)
    );

    // A start in HOLD only counts when the pending result is taken in the same cycle.
    assign restart = bus.start_in & ((state_q == S_IDLE) | (state_q == S_ACCUM) |
                                     ((state_q == S_HOLD) & bus.res_ready_in));
    assign accept  = bus.bit_valid_in & rdy_q & (state_q == S_ACCUM);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        rel_d     = rel_q;
        err_d     = err_q;
        if (restart) begin
            state_d   = S_ACCUM;
            cnt_d     = CW'(WIDTH);
            decided_d = 1'b0;
            rel_d     = REL_EQ;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (accept) begin
                        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
                        case (cls)
                            BEAT_GT: if (!decided_q) begin rel_d = REL_GT; decided_d = 1'b1; end
                            BEAT_LT: if (!decided_q) begin rel_d = REL_LT; decided_d = 1'b1; end
                            BEAT_ERR: err_d = 1'b1;
                            default: ;
                        endcase
                        if (cnt_q <= CW'(1)) state_d = S_HOLD;
                    end
                end
                S_HOLD:  if (bus.res_ready_in) state_d = S_IDLE;
                S_IDLE:  ;
                default: state_d = S_IDLE;
            endcase
        end
        rdy_d  = (state_d == S_ACCUM);
        done_d = (state_d == S_HOLD);
        res_d  = (state_d == S_HOLD) ? rel_d : REL_NONE;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            rel_q     <= REL_NONE;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= REL_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            rel_q     <= rel_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
            done_q    <= done_d;
            res_q     <= res_d;
        end
    end

    assign bus.bit_ready_out = rdy_q;
    assign bus.done_out      = done_q;
    assign bus.err_out       = err_q;
    assign bus.g_out         = res_q[2];
    assign bus.e_out         = res_q[1];
    assign bus.l_out         = res_q[0];
endmodule
